// File: rtl/decode_pkg.sv
// Shared encodings for the ID stage: opcode/funct values, ALU controls and
// compare/branch classes.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;

    localparam logic [2:0] ALUCTR_ADD = 3'd0;
    localparam logic [2:0] ALUCTR_SUB = 3'd1;
    localparam logic [2:0] ALUCTR_SLT = 3'd2;
    localparam logic [2:0] ALUCTR_AND = 3'd3;
    localparam logic [2:0] ALUCTR_OR  = 3'd4;

    localparam logic [2:0] CMP_NONE = 3'd0;
    localparam logic [2:0] CMP_BEQ  = 3'd1;
    localparam logic [2:0] CMP_J    = 3'd2;
    localparam logic [2:0] CMP_BNE  = 3'd3;

endpackage

// File: rtl/regfile_bypass.sv
// Register file with two combinational read ports, one write port and
// same-cycle write-through bypass; register 0 is hard-wired to zero.
module regfile_bypass #(
    parameter int DATA_W  = 32,
    parameter int REG_NUM = 32,
    parameter int REG_AW  = $clog2(REG_NUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs_reg [REG_NUM];
    logic [REG_AW-1:0] raddr_arr [2];
    logic [DATA_W-1:0] rdata_arr [2];
    logic              wr_live;

    assign wr_live = we && (waddr != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_live) begin
            regs_reg[waddr] <= wdata;
        end
    end

    assign raddr_arr[0] = raddr_a;
    assign raddr_arr[1] = raddr_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                rdata_arr[gi] = '0;
                if (raddr_arr[gi] == '0) begin
                    rdata_arr[gi] = '0;
                end else if (wr_live && (waddr == raddr_arr[gi])) begin
                    rdata_arr[gi] = wdata;
                end else begin
                    rdata_arr[gi] = regs_reg[raddr_arr[gi]];
                end
            end
        end
    endgenerate

    assign rdata_a = rdata_arr[0];
    assign rdata_b = rdata_arr[1];

endmodule

// File: rtl/decode_stage_hz.sv
// ID stage: register read with bypass, decode, load-use stall and flush into
// the D/X register. ID_PERF_CNT_EN adds saturating stall/illegal counters.
module decode_stage_hz
    import decode_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_NUM  = 32,
    parameter int ALUCTR_W = 3,
    localparam int REG_AW  = $clog2(REG_NUM)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid,
    input  logic [31:0]         if_ir,
    input  logic [DATA_W-1:0]   if_pc,
    input  logic                flush,
    input  logic                wb_en,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic [DATA_W-1:0]   wb_data,
    output logic                id_stall,
    output logic                dx_valid,
    output logic [DATA_W-1:0]   dx_a,
    output logic [DATA_W-1:0]   dx_b,
    output logic [DATA_W-1:0]   dx_st_data,
    output logic [REG_AW-1:0]   dx_rd,
    output logic [ALUCTR_W-1:0] dx_aluctr,
    output logic                dx_lw,
    output logic                dx_sw,
    output logic [2:0]          dx_cmp,
    output logic [DATA_W-1:0]   dx_pc,
    output logic                dx_illegal
`ifdef ID_PERF_CNT_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         illegal_cnt
`endif
);

    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic [REG_AW-1:0]   rs_addr;
    logic [REG_AW-1:0]   rt_addr;
    logic [REG_AW-1:0]   rd_field;
    logic [DATA_W-1:0]   rs_data;
    logic [DATA_W-1:0]   rt_data;
    logic [DATA_W-1:0]   sext_imm;
    logic [DATA_W-1:0]   zext_tgt;

    logic [DATA_W-1:0]   dec_b;
    logic [REG_AW-1:0]   dec_rd;
    logic [ALUCTR_W-1:0] dec_alu;
    logic                dec_lw;
    logic                dec_sw;
    logic [2:0]          dec_cmp;
    logic                dec_ill;
    logic                uses_rt;
    logic                load_use;
    logic                bubble;

    assign opcode   = if_ir[31:26];
    assign funct    = if_ir[5:0];
    assign rs_addr  = REG_AW'(if_ir[25:21]);
    assign rt_addr  = REG_AW'(if_ir[20:16]);
    assign rd_field = REG_AW'(if_ir[15:11]);
    assign sext_imm = {{(DATA_W-16){if_ir[15]}}, if_ir[15:0]};

    always_comb begin
        zext_tgt       = '0;
        zext_tgt[25:0] = if_ir[25:0];
    end

    regfile_bypass #(
        .DATA_W  (DATA_W),
        .REG_NUM (REG_NUM),
        .REG_AW  (REG_AW)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_en),
        .waddr   (wb_rd),
        .wdata   (wb_data),
        .raddr_a (rs_addr),
        .raddr_b (rt_addr),
        .rdata_a (rs_data),
        .rdata_b (rt_data)
    );

    always_comb begin
        dec_b   = rt_data;
        dec_rd  = '0;
        dec_alu = ALUCTR_W'(ALUCTR_ADD);
        dec_lw  = 1'b0;
        dec_sw  = 1'b0;
        dec_cmp = CMP_NONE;
        dec_ill = 1'b0;
        uses_rt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                uses_rt = 1'b1;
                dec_rd  = rd_field;
                case (funct)
                    FN_ADD:  dec_alu = ALUCTR_W'(ALUCTR_ADD);
                    FN_SUB:  dec_alu = ALUCTR_W'(ALUCTR_SUB);
                    FN_SLT:  dec_alu = ALUCTR_W'(ALUCTR_SLT);
                    FN_AND:  dec_alu = ALUCTR_W'(ALUCTR_AND);
                    FN_OR:   dec_alu = ALUCTR_W'(ALUCTR_OR);
                    default: begin
                        dec_ill = 1'b1;
                        dec_rd  = '0;
                    end
                endcase
            end
            OP_ADDI: begin
                dec_b  = sext_imm;
                dec_rd = rt_addr;
            end
            OP_LW: begin
                dec_b  = sext_imm;
                dec_rd = rt_addr;
                dec_lw = 1'b1;
            end
            OP_SW: begin
                uses_rt = 1'b1;
                dec_b   = sext_imm;
                dec_sw  = 1'b1;
            end
            OP_BEQ: begin
                uses_rt = 1'b1;
                dec_b   = sext_imm;
                dec_alu = ALUCTR_W'(ALUCTR_SLT);
                dec_cmp = CMP_BEQ;
            end
            OP_BNE: begin
                uses_rt = 1'b1;
                dec_b   = sext_imm;
                dec_alu = ALUCTR_W'(ALUCTR_SLT);
                dec_cmp = CMP_BNE;
            end
            OP_J: begin
                dec_b   = zext_tgt;
                dec_alu = ALUCTR_W'(ALUCTR_SLT);
                dec_cmp = CMP_J;
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // The load in D/X has not produced its data yet; the re-decode next cycle
    // sees a bubble in D/X and therefore cannot stall again.
    assign load_use = if_valid && dx_valid && dx_lw && (dx_rd != '0) &&
                      ((dx_rd == rs_addr) || (uses_rt && (dx_rd == rt_addr)));
    assign id_stall = rst && !flush && load_use;
    assign bubble   = !if_valid || flush || load_use;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || bubble) begin
            dx_valid   <= 1'b0;
            dx_a       <= '0;
            dx_b       <= '0;
            dx_st_data <= '0;
            dx_rd      <= '0;
            dx_aluctr  <= '0;
            dx_lw      <= 1'b0;
            dx_sw      <= 1'b0;
            dx_cmp     <= '0;
            dx_pc      <= '0;
            dx_illegal <= 1'b0;
        end else begin
            dx_valid   <= 1'b1;
            dx_a       <= rs_data;
            dx_b       <= dec_b;
            dx_st_data <= rt_data;
            dx_rd      <= dec_rd;
            dx_aluctr  <= dec_alu;
            dx_lw      <= dec_lw;
            dx_sw      <= dec_sw;
            dx_cmp     <= dec_cmp;
            dx_pc      <= if_pc;
            dx_illegal <= dec_ill;
        end
    end

`ifdef ID_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt   <= '0;
            illegal_cnt <= '0;
        end else begin
            if (id_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (!bubble && dec_ill && (illegal_cnt != '1)) begin
                illegal_cnt <= illegal_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage_hz.sv
// Self-checking bench for decode_stage_hz: directed scenarios followed by
// random instruction streams scored against an architectural model.
module tb_decode_stage_hz;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_ir;
    logic [31:0] if_pc;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        id_stall;
    logic        dx_valid;
    logic [31:0] dx_a;
    logic [31:0] dx_b;
    logic [31:0] dx_st_data;
    logic [4:0]  dx_rd;
    logic [2:0]  dx_aluctr;
    logic        dx_lw;
    logic        dx_sw;
    logic [2:0]  dx_cmp;
    logic [31:0] dx_pc;
    logic        dx_illegal;
`ifdef ID_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] illegal_cnt;
`endif

    always #5 clk = ~clk;

    decode_stage_hz dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_ir      (if_ir),
        .if_pc      (if_pc),
        .flush      (flush),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .id_stall   (id_stall),
        .dx_valid   (dx_valid),
        .dx_a       (dx_a),
        .dx_b       (dx_b),
        .dx_st_data (dx_st_data),
        .dx_rd      (dx_rd),
        .dx_aluctr  (dx_aluctr),
        .dx_lw      (dx_lw),
        .dx_sw      (dx_sw),
        .dx_cmp     (dx_cmp),
        .dx_pc      (dx_pc),
        .dx_illegal (dx_illegal)
`ifdef ID_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .illegal_cnt(illegal_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Architectural model: register contents and the expected D/X entry.
    logic [31:0] m_regs [32];
    bit          e_valid, e_lw, e_sw, e_ill, care_a, care_b, care_st;
    logic [31:0] e_a, e_b, e_st, e_pc;
    logic [4:0]  e_rd;
    logic [2:0]  e_alu, e_cmp;
    bit          last_stall;
    int          m_stall, m_ill;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        e_valid = 0; e_lw = 0; e_sw = 0; e_ill = 0;
        care_a = 0; care_b = 0; care_st = 0;
        e_a = '0; e_b = '0; e_st = '0; e_pc = '0; e_rd = '0; e_alu = '0; e_cmp = '0;
        last_stall = 0; m_stall = 0; m_ill = 0;
    endtask

    function automatic logic [31:0] rd_model(logic [4:0] r, bit we, logic [4:0] wr, logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
        if (we && wr == r) return wd;
        return m_regs[r];
    endfunction

    function automatic logic [31:0] enc_r(int fn, int rs, int rt, int rd);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(int tgt);
        return {6'd2, 26'(tgt)};
    endfunction

    task automatic check_dx(input string where);
        chk({where, ".valid"}, dx_valid, e_valid);
        chk({where, ".lw"}, dx_lw, e_lw);
        chk({where, ".sw"}, dx_sw, e_sw);
        chk({where, ".illegal"}, dx_illegal, e_ill);
        chk({where, ".cmp"}, dx_cmp, e_cmp);
        if (e_valid) begin
            chk({where, ".rd"}, dx_rd, e_rd);
            chk({where, ".aluctr"}, dx_aluctr, e_alu);
            chk({where, ".pc"}, dx_pc, e_pc);
        end
        if (care_a)  chk({where, ".a"}, dx_a, e_a);
        if (care_b)  chk({where, ".b"}, dx_b, e_b);
        if (care_st) chk({where, ".st_data"}, dx_st_data, e_st);
`ifdef ID_PERF_CNT_EN
        chk({where, ".stall_cnt"}, stall_cnt, m_stall);
        chk({where, ".illegal_cnt"}, illegal_cnt, m_ill);
`endif
    endtask

    task automatic check_all_zero(input string where);
        chk({where, ".id_stall"}, id_stall, 0);
        chk({where, ".valid"}, dx_valid, 0);
        chk({where, ".a"}, dx_a, 0);
        chk({where, ".b"}, dx_b, 0);
        chk({where, ".st_data"}, dx_st_data, 0);
        chk({where, ".rd"}, dx_rd, 0);
        chk({where, ".aluctr"}, dx_aluctr, 0);
        chk({where, ".flags"}, {dx_lw, dx_sw, dx_illegal, dx_cmp}, 0);
        chk({where, ".pc"}, dx_pc, 0);
`ifdef ID_PERF_CNT_EN
        chk({where, ".counters"}, {stall_cnt, illegal_cnt}, 0);
`endif
    endtask

    // One clock: drive, check the combinational stall, advance the model, check D/X.
    task automatic cyc(input string tag, input bit v, input logic [31:0] ir, input logic [31:0] pc,
                       input bit fl, input bit we, input logic [4:0] wr, input logic [31:0] wd);
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rdf;
        logic [31:0] ra, rb, sx, zx;
        bit          urt, st;
        @(negedge clk);
        if_valid = v; if_ir = ir; if_pc = pc; flush = fl;
        wb_en = we; wb_rd = wr; wb_data = wd;
        #1;
        op = ir[31:26]; fn = ir[5:0];
        rs = ir[25:21]; rt = ir[20:16]; rdf = ir[15:11];
        ra = rd_model(rs, we, wr, wd);
        rb = rd_model(rt, we, wr, wd);
        sx = {{16{ir[15]}}, ir[15:0]};
        zx = {6'd0, ir[25:0]};
        urt = (op == 6'd0) || (op == 6'd43) || (op == 6'd4) || (op == 6'd5);
        st = v && !fl && e_valid && e_lw && (e_rd != 5'd0) &&
             ((e_rd == rs) || (urt && (e_rd == rt)));
        chk({tag, ".id_stall"}, id_stall, st);
        last_stall = st;
        @(posedge clk);
        if (we && wr != 5'd0) m_regs[wr] = wd;
        if (st) m_stall++;
        if (!v || fl || st) begin
            e_valid = 0; e_lw = 0; e_sw = 0; e_ill = 0; e_cmp = '0;
            care_a = 0; care_b = 0; care_st = 0;
        end else begin
            e_valid = 1; e_pc = pc; e_a = ra; e_b = rb; e_st = rb;
            care_a = 1; care_b = 1; care_st = 0;
            e_rd = '0; e_alu = '0; e_lw = 0; e_sw = 0; e_cmp = '0; e_ill = 0;
            case (op)
                6'd0: begin
                    e_rd = rdf;
                    case (fn)
                        6'd32: e_alu = 3'd0;
                        6'd34: e_alu = 3'd1;
                        6'd42: e_alu = 3'd2;
                        6'd36: e_alu = 3'd3;
                        6'd37: e_alu = 3'd4;
                        default: begin e_ill = 1; e_rd = '0; care_a = 0; care_b = 0; end
                    endcase
                end
                6'd8:  begin e_b = sx; e_rd = rt; end
                6'd35: begin e_b = sx; e_rd = rt; e_lw = 1; end
                6'd43: begin e_b = sx; e_sw = 1; care_st = 1; end
                6'd4:  begin e_b = sx; e_alu = 3'd2; e_cmp = 3'd1; care_st = 1; end
                6'd5:  begin e_b = sx; e_alu = 3'd2; e_cmp = 3'd3; care_st = 1; end
                6'd2:  begin e_b = zx; e_alu = 3'd2; e_cmp = 3'd2; care_a = 0; end
                default: begin e_ill = 1; care_a = 0; care_b = 0; end
            endcase
            if (e_ill) m_ill++;
        end
        #1;
        check_dx(tag);
    endtask

    function automatic logic [31:0] rand_ir();
        int k, rs, rt, rd, imm;
        k = $urandom_range(0, 11);
        rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
        imm = $urandom_range(0, 65535);
        case (k)
            0: return enc_r(32, rs, rt, rd);
            1: return enc_r(34, rs, rt, rd);
            2: return enc_r(42, rs, rt, rd);
            3: return enc_r(36, rs, rt, rd);
            4: return enc_r(37, rs, rt, rd);
            5: return enc_i(8, rs, rt, imm);
            6, 7: return enc_i(35, rs, rt, imm);
            8: return enc_i(43, rs, rt, imm);
            9: return enc_i($urandom_range(4, 5), rs, rt, imm);
            10: return enc_j($urandom);
            default: return ($urandom_range(0, 1) == 0) ? enc_i(63, rs, rt, imm) : enc_r(0, rs, rt, rd);
        endcase
    endfunction

    initial begin
        logic [31:0] cur_ir, cur_pc;
        bit v;
        rst = 1'b0; if_valid = 0; if_ir = '0; if_pc = '0; flush = 0;
        wb_en = 0; wb_rd = '0; wb_data = '0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        cyc("wb_r1", 0, 32'd0, 32'h0, 0, 1, 5'd1, 32'd5);
        cyc("wb_r2", 0, 32'd0, 32'h0, 0, 1, 5'd2, 32'd3);
        cyc("add_r3", 1, enc_r(32, 1, 2, 3), 32'h100, 0, 0, 5'd0, 32'd0);
        chk("add_r3.a_const", dx_a, 32'd5);
        chk("add_r3.b_const", dx_b, 32'd3);
        cyc("or_bypass", 1, enc_r(37, 4, 0, 5), 32'h104, 0, 1, 5'd4, 32'h77);
        chk("or_bypass.a_const", dx_a, 32'h77);
        cyc("wb_r0_ignored", 1, enc_r(32, 0, 0, 8), 32'h108, 0, 1, 5'd0, 32'h55);
        chk("wb_r0_ignored.a_const", dx_a, 32'd0);

        cyc("lw_r6", 1, enc_i(35, 1, 6, 8), 32'h10c, 0, 0, 5'd0, 32'd0);
        cyc("add_use_stall", 1, enc_r(32, 6, 2, 7), 32'h110, 0, 0, 5'd0, 32'd0);
        chk("add_use_stall.stall_const", last_stall, 1);
        cyc("add_use_issue", 1, enc_r(32, 6, 2, 7), 32'h110, 0, 0, 5'd0, 32'd0);
        cyc("lw_r6b", 1, enc_i(35, 1, 6, 8), 32'h114, 0, 0, 5'd0, 32'd0);
        cyc("add_no_use", 1, enc_r(32, 1, 2, 7), 32'h118, 0, 0, 5'd0, 32'd0);

        cyc("beq_neg", 1, enc_i(4, 1, 2, 32'hFFFC), 32'h11c, 0, 0, 5'd0, 32'd0);
        chk("beq_neg.b_const", dx_b, 32'hFFFFFFFC);
        cyc("j_max", 1, enc_j(32'h3FFFFFF), 32'h120, 0, 0, 5'd0, 32'd0);
        chk("j_max.b_const", dx_b, 32'h03FFFFFF);
        cyc("op63", 1, enc_i(63, 1, 2, 0), 32'h124, 0, 0, 5'd0, 32'd0);
        chk("op63.illegal_const", dx_illegal, 1'b1);

        cyc("lw_r6c", 1, enc_i(35, 1, 6, 8), 32'h128, 0, 0, 5'd0, 32'd0);
        cyc("flush_over_stall", 1, enc_r(32, 6, 2, 7), 32'h12c, 1, 0, 5'd0, 32'd0);
        cyc("after_flush", 1, enc_r(32, 6, 2, 7), 32'h12c, 0, 0, 5'd0, 32'd0);

        cur_ir = rand_ir();
        cur_pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                cur_ir = rand_ir();
                cur_pc = cur_pc + 32'd4;
            end
            v = last_stall ? 1'b1 : ($urandom_range(0, 9) != 0);
            cyc("rand", v, cur_ir, cur_pc, ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
        end

        cyc("pre_rst_lw", 1, enc_i(35, 1, 6, 8), 32'h200, 0, 0, 5'd0, 32'd0);
        @(negedge clk);
        if_valid = 1; if_ir = enc_r(32, 6, 2, 7); if_pc = 32'h204;
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc("post_rst_add", 1, enc_r(32, 1, 2, 3), 32'h300, 0, 0, 5'd0, 32'd0);
        chk("post_rst_add.a_const", dx_a, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
